phy_os_scheduler: RTL

Ordered-set scheduler that sequences the PHY-to-MAC receive driver path. It decides which ordered set goes out byte-by-byte on rxdata/rxdatak/rxvalid: SKP, TS1 or TS2. The choice follows the LTSSM state, and SKP sets are inserted periodically. TS bytes 1-5 are snapshotted at each ordered-set start, so a set is never torn. The block sits between the LTSSM and the driver lanes, in place of the free-running per-state sequence pointer.

---
 rtl/ozdefs.sv | 68 ++++++
 rtl/phy_skp_timer.sv | 49 ++++
 rtl/phy_os_scheduler.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ozdefs.sv
// Shared PHY receive-path definitions: LTSSM states, ordered-set symbols and
// the scheduler's set/state encodings.
package ozdefs;

    typedef enum logic [4:0] {
        DETECT_QUIET             = 5'd0,
        DETECT_ACTIVE            = 5'd1,
        POLLING_ACTIVE           = 5'd2,
        POLLING_ACTIVE_START_TS1 = 5'd3,
        POLLING_CONFIG           = 5'd4,
        POLLING_COMPLIANCE       = 5'd5,
        CONFIG_LINKWIDTH_START   = 5'd6,
        CONFIG_LINKWIDTH_ACCEPT  = 5'd7,
        CONFIG_LANENUM_WAIT      = 5'd8,
        CONFIG_COMPLETE          = 5'd9,
        CONFIG_IDLE              = 5'd10,
        L0                       = 5'd11,
        RECOVERY_RCVRLOCK        = 5'd12,
        RECOVERY_IDLE            = 5'd13,
        HOT_RESET                = 5'd14,
        DISABLED                 = 5'd15
    } LTSSM_State;

    localparam logic [7:0] COM   = 8'hBC;
    localparam logic [7:0] SKP   = 8'h1C;
    localparam logic [7:0] TS1ID = 8'h4A;
    localparam logic [7:0] TS2ID = 8'h45;
    localparam logic [7:0] PAD   = 8'hF7;

    typedef enum logic [1:0] {
        OS_NONE = 2'd0,
        OS_SKP  = 2'd1,
        OS_TS1  = 2'd2,
        OS_TS2  = 2'd3
    } os_type_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SKP_OS = 2'd1,
        TS1_OS = 2'd2,
        TS2_OS = 2'd3
    } os_state_t;

    localparam logic [3:0] SKP_LAST_BYTE = 4'd3;
    localparam logic [3:0] TS_LAST_BYTE  = 4'd15;

    function automatic os_type_t base_os_type(input LTSSM_State st);
        case (st)
            POLLING_ACTIVE:           return OS_SKP;
            POLLING_ACTIVE_START_TS1: return OS_TS1;
            POLLING_CONFIG:           return OS_TS2;
            default:                  return OS_NONE;
        endcase
    endfunction

    // Byte k (1..5) of a packed TS field lives at [8k-1:8k-8].
    function automatic logic [7:0] ts_field(input logic [39:0] v, input logic [3:0] idx);
        case (idx)
            4'd1:    return v[7:0];
            4'd2:    return v[15:8];
            4'd3:    return v[23:16];
            4'd4:    return v[31:24];
            4'd5:    return v[39:32];
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/phy_skp_timer.sv
// SKP insertion interval timer holding a single sticky insertion request.
module phy_skp_timer
    import ozdefs::*;
#(
    parameter int SKP_INTERVAL = 1180
) (
    input  logic clk,
    input  logic p2md_rstn,
    input  logic run,
    input  logic clr_pending,
    output logic pending
);

    logic [15:0] count_r;
    logic        pending_r;
    logic        expire_s;

    // Expiry happens on the cycle the counter sits at its terminal value.
    always_comb begin
        expire_s = run && (count_r == 16'(SKP_INTERVAL - 1));
    end

    // Interval counter and request flag; a same-cycle expiry beats the clear.
    always_ff @(posedge clk or negedge p2md_rstn) begin
        if (!p2md_rstn) begin
            count_r   <= 16'd0;
            pending_r <= 1'b0;
        end else begin
            if (expire_s) begin
                count_r <= 16'd0;
            end else if (run) begin
                count_r <= count_r + 16'd1;
            end else begin
                count_r <= count_r;
            end

            if (expire_s) begin
                pending_r <= 1'b1;
            end else if (clr_pending) begin
                pending_r <= 1'b0;
            end else begin
                pending_r <= pending_r;
            end
        end
    end

    assign pending = pending_r;

endmodule

// File: rtl/phy_os_scheduler.sv
// Ordered-set scheduler: picks SKP/TS1/TS2 from the LTSSM state, inserts
// periodic SKP sets and streams the chosen set one byte per cycle.
module phy_os_scheduler
    import ozdefs::*;
#(
    parameter int SKP_INTERVAL = 1180
) (
    input  logic        clk,
    input  logic        p2md_rstn,
    input  logic        en_n,
    input  LTSSM_State  currLtssmState,
    input  logic [39:0] ts1Bytes1Thru5,
    input  logic [39:0] ts2Bytes1Thru5,
    output logic [7:0]  rxdata,
    output logic        rxdatak,
    output logic        rxvalid,
    output logic        os_start,
    output logic [1:0]  os_type,
    output logic [7:0]  ts_sent
);

    os_state_t   state_r;
    os_state_t   next_state_s;
    logic [3:0]  cnt_r;
    logic [39:0] snap_r;
    LTSSM_State  ltssm_r;
    os_type_t    base_s;
    os_type_t    cur_type_s;
    logic        is_ts_s;
    logic        last_s;
    logic        boundary_s;
    logic        skp_pending_s;
    logic        timer_run_s;
    logic        clr_pending_s;
    logic [7:0]  byte_s;
    logic        k_s;

    phy_skp_timer #(
        .SKP_INTERVAL(SKP_INTERVAL)
    ) u_skp_timer (
        .clk        (clk),
        .p2md_rstn  (p2md_rstn),
        .run        (timer_run_s),
        .clr_pending(clr_pending_s),
        .pending    (skp_pending_s)
    );

    // Set-boundary detection and next-set selection.
    always_comb begin
        base_s  = base_os_type(currLtssmState);
        is_ts_s = (state_r == TS1_OS) || (state_r == TS2_OS);
        if (state_r == SKP_OS) begin
            last_s = (cnt_r == SKP_LAST_BYTE);
        end else if (is_ts_s) begin
            last_s = (cnt_r == TS_LAST_BYTE);
        end else begin
            last_s = 1'b0;
        end
        boundary_s = (state_r == IDLE) || last_s;

        // A NONE base parks in IDLE but leaves any SKP request outstanding.
        if (en_n) begin
            next_state_s = IDLE;
        end else if (base_s == OS_NONE) begin
            next_state_s = IDLE;
        end else if (skp_pending_s) begin
            next_state_s = SKP_OS;
        end else begin
            case (base_s)
                OS_SKP:  next_state_s = SKP_OS;
                OS_TS1:  next_state_s = TS1_OS;
                OS_TS2:  next_state_s = TS2_OS;
                default: next_state_s = IDLE;
            endcase
        end

        clr_pending_s = boundary_s && (next_state_s == SKP_OS);
        timer_run_s   = !en_n && (base_s != OS_NONE);
    end

    // Symbol generation for the byte currently addressed by state_r/cnt_r.
    always_comb begin
        byte_s     = 8'h00;
        k_s        = 1'b0;
        cur_type_s = OS_NONE;
        case (state_r)
            SKP_OS: begin
                cur_type_s = OS_SKP;
                byte_s     = (cnt_r == 4'd0) ? COM : SKP;
                k_s        = 1'b1;
            end
            TS1_OS, TS2_OS: begin
                cur_type_s = (state_r == TS1_OS) ? OS_TS1 : OS_TS2;
                if (cnt_r == 4'd0) begin
                    byte_s = COM;
                    k_s    = 1'b1;
                end else if (cnt_r <= 4'd5) begin
                    byte_s = ts_field(snap_r, cnt_r);
                    k_s    = (byte_s == PAD);
                end else begin
                    byte_s = (state_r == TS1_OS) ? TS1ID : TS2ID;
                    k_s    = 1'b0;
                end
            end
            default: begin
                byte_s     = 8'h00;
                k_s        = 1'b0;
                cur_type_s = OS_NONE;
            end
        endcase
    end

    // Sequencer state, byte counter and registered driver outputs.
    always_ff @(posedge clk or negedge p2md_rstn) begin
        if (!p2md_rstn) begin
            state_r  <= IDLE;
            cnt_r    <= 4'd0;
            rxdata   <= 8'h00;
            rxdatak  <= 1'b0;
            rxvalid  <= 1'b0;
            os_start <= 1'b0;
            os_type  <= OS_NONE;
        end else begin
            rxdata   <= byte_s;
            rxdatak  <= k_s;
            rxvalid  <= (state_r != IDLE);
            os_start <= (state_r != IDLE) && (cnt_r == 4'd0);
            os_type  <= cur_type_s;
            if (boundary_s) begin
                state_r <= next_state_s;
                cnt_r   <= 4'd0;
            end else begin
                state_r <= state_r;
                cnt_r   <= cnt_r + 4'd1;
            end
        end
    end

    // TS bytes 1-5 are frozen while COM goes out so a set is never torn.
    always_ff @(posedge clk or negedge p2md_rstn) begin
        if (!p2md_rstn) begin
            snap_r <= 40'h00_0000_0000;
        end else if ((state_r == TS1_OS) && (cnt_r == 4'd0)) begin
            snap_r <= ts1Bytes1Thru5;
        end else if ((state_r == TS2_OS) && (cnt_r == 4'd0)) begin
            snap_r <= ts2Bytes1Thru5;
        end else begin
            snap_r <= snap_r;
        end
    end

    // Completed-TS counter; an LTSSM change clears it and wins over a count.
    always_ff @(posedge clk or negedge p2md_rstn) begin
        if (!p2md_rstn) begin
            ltssm_r <= DETECT_QUIET;
            ts_sent <= 8'd0;
        end else begin
            ltssm_r <= currLtssmState;
            if (currLtssmState != ltssm_r) begin
                ts_sent <= 8'd0;
            end else if (is_ts_s && last_s && (ts_sent != 8'hFF)) begin
                ts_sent <= ts_sent + 8'd1;
            end else begin
                ts_sent <= ts_sent;
            end
        end
    end

endmodule
